vga_fill_master: RTL

VGA_FILL_MASTER -- requirements
Module: vga_fill_master

---
 rtl/vga_fill_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_fill_master.sv
// Rectangle fill engine: clips a command to the screen and streams one Avalon-MM write per pixel in raster order.
// Optional build macro VGA_FILL_COUNT_EN adds the pix_count output (accepted writes of the current command).
module vga_fill_master #(
    parameter int XRES = 160,
    parameter int YRES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [6:0]  y0,
    input  logic [6:0]  y1,
    input  logic [2:0]  colour,
    output logic        busy,
    output logic        done,
    output logic [3:0]  m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef VGA_FILL_COUNT_EN
    ,
    output logic [14:0] pix_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_WRITE, S_FINISH} state_t;

    localparam logic [7:0] XMAX = 8'(XRES - 1);
    localparam logic [6:0] YMAX = 7'(YRES - 1);

    state_t     state_q, state_d;
    logic [7:0] x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
    logic [6:0] y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d;
    logic [2:0] colour_q, colour_d;
    logic [7:0] x1_clip;
    logic [6:0] y1_clip;

    assign x1_clip = (x1_q > XMAX) ? XMAX : x1_q;
    assign y1_clip = (y1_q > YMAX) ? YMAX : y1_q;

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        colour_d = colour_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    x1_d     = x1;
                    y0_d     = y0;
                    y1_d     = y1;
                    colour_d = colour;
                    state_d  = S_CLIP;
                end
            end
            S_CLIP: begin
                x1_d = x1_clip;
                y1_d = y1_clip;
                // An off-screen origin is also caught by x0 > x1_clip, kept explicit for readability.
                if (x0_q > x1_clip || y0_q > y1_clip || x0_q > XMAX || y0_q > YMAX) begin
                    state_d = S_FINISH;
                end else begin
                    cur_x_d = x0_q;
                    cur_y_d = y0_q;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!m_waitrequest) begin
                    if (cur_x_q == x1_q) begin
                        if (cur_y_q == y1_q) begin
                            state_d = S_FINISH;
                        end else begin
                            cur_x_d = x0_q;
                            cur_y_d = cur_y_q + 7'd1;
                        end
                    end else begin
                        cur_x_d = cur_x_q + 8'd1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            colour_q <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            colour_q <= colour_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign m_write     = (state_q == S_WRITE);
    assign m_address   = 4'b0000;
    assign m_writedata = m_write ? {13'b0, colour_q, cur_x_q, 1'b0, cur_y_q} : 32'h0;

`ifdef VGA_FILL_COUNT_EN
    logic [14:0] pix_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_count_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            pix_count_q <= '0;
        end else if (state_q == S_WRITE && !m_waitrequest) begin
            pix_count_q <= pix_count_q + 15'd1;
        end
    end

    assign pix_count = pix_count_q;
`endif

endmodule
